// File: rtl/ofifo_param.sv
// Multi-column output FIFO: COL independent circular buffers that pop together as one row.
// Optional sticky error flags are built when OFIFO_ERR_FLAG_EN is defined.
module ofifo_param #(
    parameter int unsigned COL      = 8,
    parameter int unsigned BW       = 4,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AFULL_TH = DEPTH - 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COL-1:0]            wr,
    input  logic [COL*BW-1:0]         in,
    input  logic                      rd,
    output logic [COL*BW-1:0]         out,
    output logic                      o_rd_valid,
    output logic                      o_full,
    output logic                      o_ready,
    output logic                      o_afull,
    output logic                      o_valid,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [1:0]                o_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BW-1:0]     mem_q  [COL][DEPTH];
    logic [AW-1:0]     wptr_q [COL];
    logic [AW-1:0]     wptr_d [COL];
    logic [AW-1:0]     rptr_q [COL];
    logic [AW-1:0]     rptr_d [COL];
    logic [CW-1:0]     cnt_q  [COL];
    logic [CW-1:0]     cnt_d  [COL];
    logic [COL*BW-1:0] out_q;
    logic [COL*BW-1:0] out_d;
    logic              rdv_q;
    logic              en_q;
    logic [COL-1:0]    wr_ok;
    logic              pop;
    logic              full_c;
    logic              afull_c;
    logic              valid_c;
    logic [CW-1:0]     min_c;

    // Status flags from the registered occupancies.
    always_comb begin
        full_c  = 1'b0;
        afull_c = 1'b0;
        valid_c = 1'b1;
        min_c   = CW'(DEPTH);
        for (int unsigned i = 0; i < COL; i++) begin
            if (cnt_q[i] == CW'(DEPTH))    full_c  = 1'b1;
            if (cnt_q[i] >= CW'(AFULL_TH)) afull_c = 1'b1;
            if (cnt_q[i] == '0)            valid_c = 1'b0;
            if (cnt_q[i] < min_c)          min_c   = cnt_q[i];
        end
    end

    // en_q gates the first edge the flops see with reset high (the release edge).
    always_comb begin
        pop   = en_q & rd & valid_c;
        out_d = out_q;
        for (int unsigned i = 0; i < COL; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            cnt_d[i]  = cnt_q[i];
            wr_ok[i]  = en_q & wr[i] & ((cnt_q[i] != CW'(DEPTH)) | pop);
            if (wr_ok[i]) wptr_d[i] = wptr_q[i] + AW'(1);
            if (pop) begin
                rptr_d[i]          = rptr_q[i] + AW'(1);
                out_d[BW*i +: BW]  = mem_q[i][rptr_q[i]];
            end
            case ({wr_ok[i], pop})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '{default: '0};
            rptr_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            out_q  <= '0;
            rdv_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rdv_q  <= pop;
            en_q   <= 1'b1;
        end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < COL; i++) begin
            if (wr_ok[i]) mem_q[i][wptr_q[i]] <= in[BW*i +: BW];
        end
    end

`ifdef OFIFO_ERR_FLAG_EN
    logic [1:0] err_q;
    logic [1:0] err_d;

    // Sticky {ignored pop, dropped write}.
    always_comb begin
        err_d = err_q;
        if (en_q & rd & ~valid_c)   err_d[1] = 1'b1;
        if (en_q & |(wr & ~wr_ok))  err_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 2'b00;
        else        err_q <= err_d;
    end

    assign o_err = err_q;
`else
    assign o_err = 2'b00;
`endif

    assign out        = out_q;
    assign o_rd_valid = rdv_q;
    assign o_full     = full_c;
    assign o_ready    = ~full_c;
    assign o_afull    = afull_c;
    assign o_valid    = valid_c;
    assign o_count    = min_c;

endmodule

// File: tb/tb_ofifo_param.sv
// Scoreboard bench for ofifo_param: per-column queue model, popped rows checked by a monitor.
module tb_ofifo_param;

    localparam int unsigned COL      = 8;
    localparam int unsigned BW       = 4;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned AFULL_TH = DEPTH - 4;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    typedef logic [BW-1:0]     word_t;
    typedef logic [COL*BW-1:0] row_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [COL-1:0]    wr = '0;
    row_t              in = '0;
    logic              rd = 1'b0;
    row_t              out;
    logic              o_rd_valid, o_full, o_ready, o_afull, o_valid;
    logic [CW-1:0]     o_count;
    logic [1:0]        o_err;

    always #5 clk = ~clk;

    ofifo_param #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
        .o_rd_valid(o_rd_valid), .o_full(o_full), .o_ready(o_ready),
        .o_afull(o_afull), .o_valid(o_valid), .o_count(o_count), .o_err(o_err)
    );

    word_t      mq [COL][$];
    row_t       expq [$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_err = 2'b00;
    row_t       exp_out = '0;
    logic       exp_rdv = 1'b0;
    bit         ign = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int unsigned c = 0; c < COL; c++) r[c*BW +: BW] = word_t'($urandom);
        return r;
    endfunction

    function automatic logic [COL-1:0] rand_mask(int unsigned pct);
        logic [COL-1:0] m;
        for (int unsigned c = 0; c < COL; c++) m[c] = ($urandom_range(0, 99) < pct);
        return m;
    endfunction

    task automatic check_flags();
        int sz, mn;
        bit full, afull, valid;
        mn = DEPTH; full = 0; afull = 0; valid = 1;
        for (int unsigned c = 0; c < COL; c++) begin
            sz = mq[c].size();
            if (sz < mn) mn = sz;
            if (sz == int'(DEPTH)) full = 1;
            if (sz >= int'(AFULL_TH)) afull = 1;
            if (sz == 0) valid = 0;
        end
        chk("o_valid",    64'(o_valid),    64'(valid));
        chk("o_full",     64'(o_full),     64'(full));
        chk("o_ready",    64'(o_ready),    64'(!full));
        chk("o_afull",    64'(o_afull),    64'(afull));
        chk("o_count",    64'(o_count),    64'(mn));
        chk("out_hold",   64'(out),        64'(exp_out));
        chk("o_rd_valid", 64'(o_rd_valid), 64'(exp_rdv));
        chk("o_err",      64'(o_err),      64'(exp_err));
    endtask

    // Behavioural effect of one clock edge on the per-column queues.
    task automatic model_edge(input logic [COL-1:0] w, input row_t d, input logic r);
        bit   v, p;
        row_t row;
        exp_rdv = 1'b0;
        if (ign) begin
            ign = 1'b0;
            return;
        end
        v = 1;
        for (int unsigned c = 0; c < COL; c++) if (mq[c].size() == 0) v = 0;
        p = r && v;
`ifdef OFIFO_ERR_FLAG_EN
        if (r && !v) exp_err[1] = 1'b1;
`endif
        if (p) begin
            row = '0;
            for (int unsigned c = 0; c < COL; c++) row[c*BW +: BW] = mq[c].pop_front();
            expq.push_back(row);
            exp_out = row;
            exp_rdv = 1'b1;
        end
        for (int unsigned c = 0; c < COL; c++) begin
            if (w[c]) begin
                if (mq[c].size() < int'(DEPTH)) mq[c].push_back(d[c*BW +: BW]);
                else begin
`ifdef OFIFO_ERR_FLAG_EN
                    exp_err[0] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic step(input logic [COL-1:0] w, input row_t d, input logic r);
        check_flags();
        wr = w; in = d; rd = r;
        model_edge(w, d, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; flags must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        for (int unsigned c = 0; c < COL; c++) mq[c].delete();
        expq.delete();
        exp_err = 2'b00; exp_out = '0; exp_rdv = 1'b0;
        check_flags();
        wr = rand_mask(50); in = rand_row(); rd = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        ign = 1'b1;
        wr = '0; rd = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && o_rd_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_row: rd_valid high with no expected row, out=0x%0h at %0t", out, $time);
            end else begin
                chk("out_row", 64'(out), 64'(expq.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        row_t r;
        @(negedge clk);
        do_reset();

        // Rows 0x1..0x8 in every column, one pop.
        for (int k = 1; k <= 8; k++) begin
            for (int unsigned c = 0; c < COL; c++) r[c*BW +: BW] = word_t'(k);
            step('1, r, 1'b0);
        end
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // Only column 0 written: pop must be ignored.
        do_reset();
        step('0, '0, 1'b0);
        for (int k = 0; k < 3; k++) step(COL'(1), rand_row(), 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Fill to full, drop on overflow, accept with simultaneous pop.
        do_reset();
        step('0, '0, 1'b0);
        for (int k = 0; k < int'(DEPTH); k++) step('1, rand_row(), 1'b0);
        step('1, rand_row(), 1'b0);
        step('1, rand_row(), 1'b1);
        step('0, '0, 1'b0);

        // Randomised phases: fill-biased, drain-biased, balanced, sparse.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 400; n++) begin
                case (ph)
                    0:       step(rand_mask(85), rand_row(), $urandom_range(0, 4) == 0);
                    1:       step(rand_mask(20), rand_row(), $urandom_range(0, 4) != 0);
                    2:       step(rand_mask(60), rand_row(), $urandom_range(0, 1) == 1);
                    default: step(rand_mask(10), rand_row(), 1'b1);
                endcase
            end
        end

        // Streaming with rd held high, across pointer wrap.
        do_reset();
        step('0, '0, 1'b0);
        for (int n = 0; n < 200; n++) step('1, rand_row(), 1'b1);
        for (int n = 0; n < 4; n++) step('0, '0, 1'b1);

        // Reset with rows stored; rd ignored after release until new writes.
        for (int n = 0; n < 10; n++) step('1, rand_row(), 1'b0);
        do_reset();
        step('1, rand_row(), 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        for (int n = 0; n < 5; n++) step('1, rand_row(), 1'b1);

        // Drain and confirm every expected row was seen.
        for (int n = 0; n < int'(DEPTH) + 4; n++) step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("scoreboard_drained", 64'(expq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofifo_param.md
OFIFO_PARAM -- requirements
Module: ofifo_param

Interface
REQ-001 SHALL have parameter COL, default 8: number of independent columns (lanes).
REQ-002 SHALL have parameter BW, default 4: bits per column word.
REQ-003 SHALL have parameter DEPTH, default 64: entries per column; power of two, >= 4.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4: almost-full threshold in entries.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; 0 = reset asserted
REQ-006 SHALL have the remaining ports:
- wr  input  COL  per-column write strobe
- in  input  COL*BW  column i data at bits [BW*i +: BW]
- rd  input  1  row pop request
- out  output  COL*BW  registered popped row
- o_rd_valid  output  1  out holds a row popped on the previous edge
- o_full  output  1  any column full
- o_ready  output  1  equal to !o_full
- o_afull  output  1  any column occupancy >= AFULL_TH
- o_valid  output  1  every column non-empty (a full row is available)
- o_count  output  $clog2(DEPTH)+1  minimum occupancy over all columns
- o_err  output  2  sticky {underflow, overflow}

Function
REQ-007 SHALL give each column its own circular buffer of DEPTH words with write pointer, read pointer and occupancy counter (0..DEPTH).
REQ-008 SHALL accept a write to column i on an edge where wr[i]=1 and (column i not full, or a pop is accepted on the same edge).
REQ-009 SHALL drop a write to a full column when no pop is accepted on that edge; storage and pointers are unchanged.
REQ-010 SHALL accept a pop on an edge where rd=1 and o_valid=1; all COL read pointers advance together.
REQ-011 SHALL ignore rd when o_valid=0; pointers and out are unchanged.
REQ-012 SHALL load out with the head word of every column on the edge a pop is accepted (one-edge latency) and hold out otherwise.
REQ-013 SHALL drive o_rd_valid=1 for exactly the cycle after each accepted pop, and 0 otherwise.
REQ-014 SHALL update a column's occupancy by +1 on write only, -1 on pop only, and 0 on simultaneous write and pop.
REQ-015 SHALL wrap pointers from DEPTH-1 to 0 with no bubble.
REQ-016 SHALL derive o_full, o_afull, o_valid and o_count combinationally from the registered occupancies.
REQ-017 SHALL allow arbitrary wr patterns; columns fill independently, and a row pops only when all columns hold data.

Reset
REQ-018 SHALL, while reset=0 and without waiting for clk, clear all pointers and occupancies, out, o_rd_valid and o_err.
REQ-019 SHALL present after reset: o_full=0, o_ready=1, o_afull=0, o_valid=0, o_count=0, out=0.
REQ-020 SHALL discard all in-flight data on reset asserted mid-operation; storage contents need not be cleared.
REQ-021 SHALL ignore wr and rd on the first rising edge coincident with reset release.

Configuration
REQ-022 SHALL, with macro OFIFO_ERR_FLAG_EN defined, set o_err[0] on a dropped write (REQ-009) and o_err[1] on an ignored rd (REQ-011); both bits stay set until reset.
REQ-023 SHALL, without OFIFO_ERR_FLAG_EN, tie o_err to 2'b00 and build no error logic; the data path is identical in both builds.

Verification
REQ-024 Defaults: after reset, write rows 0x1..0x8 in all columns, pulse rd once -> out equals the first row on the next cycle, o_rd_valid high for that one cycle, o_count = 7.
REQ-025 Write column 0 only, three times, then rd=1 -> o_valid=0, pop ignored, out unchanged; o_err=2'b10 with the macro, 2'b00 without.
REQ-026 Write 64 rows -> o_full=1, o_ready=0 (o_afull=1 from 60 rows on); a 65th write with rd=0 is dropped and sets o_err[0]; a 65th write with rd=1 is accepted and o_count stays 64.
REQ-027 Stream 200 rows with rd held high and a 1-cycle write/pop offset -> data returns in order across pointer wrap, with no loss and no duplication.
REQ-028 Assert reset low mid-cycle with 10 rows stored -> all flags reach reset values before the next clk edge; after release, rd is ignored until new writes arrive.
REQ-029 Run with COL=4, BW=16, DEPTH=8, AFULL_TH=6 -> o_afull rises at 6 rows, o_full at 8, and o_count width is 4 bits.
